// File: rtl/pwm_dac_pkg.sv
// Package for the PWM / delta-sigma audio DAC output stage.
// Holds the output-mode encoding, the midscale reset level of the active
// sample, and the sign-flip constant that turns a two's-complement sample
// into offset binary.
package pwm_dac_pkg;

    // Output modulator selection, latched once per period.
    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_DSM = 1'b1
    } mode_e;

    // Active-sample level at reset: zero signal, so the pin idles at 50 %
    // and the external RC filter sees no step at turn-on.
    localparam logic [15:0] MIDSCALE  = 16'h8000;

    // XOR mask converting signed 16-bit samples to offset binary.
    localparam logic [15:0] SIGN_FLIP = 16'h8000;

    // Signed two's-complement sample to unsigned offset-binary level.
    function automatic logic [15:0] to_offset_binary(input logic [15:0] sample);
        return sample ^ SIGN_FLIP;
    endfunction

endpackage

// File: rtl/pwm_dac_out_dsm_modulator.sv
// First-order delta-sigma modulator core.
// Each enabled clock adds level_in to a DW-bit accumulator; the carry out of
// that addition is the 1-bit output, so its long-run density is
// level_in / 2^DW.
// Ports:
//   clk_in      system clock
//   reset_n_in  synchronous reset, active-low (clears accumulator)
//   clear_in    synchronous accumulator clear (priority over enable_in)
//   enable_in   1 = accumulate this clock; 0 = hold
//   level_in    unsigned level to modulate
//   carry_out   carry of acc + level_in (combinational; registered by parent)
module dsm_modulator #(
    parameter int DW = 16
) (
    input  logic          clk_in,
    input  logic          reset_n_in,
    input  logic          clear_in,
    input  logic          enable_in,
    input  logic [DW-1:0] level_in,
    output logic          carry_out
);

    logic [DW-1:0] acc_r;
    logic [DW:0]   sum_s;

    // Widened sum; its top bit is the modulator output for this clock.
    always_comb begin
        sum_s     = {1'b0, acc_r} + {1'b0, level_in};
        carry_out = sum_s[DW];
    end

    // Accumulator: keeps only the low DW bits, the carry leaves as output.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            acc_r <= {DW{1'b0}};
        end else if (clear_in) begin
            acc_r <= {DW{1'b0}};
        end else if (enable_in) begin
            acc_r <= sum_s[DW-1:0];
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/pwm_dac_out.sv
// Audio output stage: double-buffers the mixed sample and drives one output
// pin as either plain PWM or first-order delta-sigma.
// Ports:
//   clk_in            system clock
//   reset_n_in        synchronous reset, active-low
//   sample_in         signed two's-complement mixed sample
//   sample_valid_in   one-cycle strobe qualifying sample_in
//   enable_in         1 = modulator running; 0 = output parked low
//   mode_in           0 = PWM, 1 = DSM; taken at the period boundary
//   pwm_out           registered 1-bit DAC output
//   period_start_out  one-cycle pulse on the first clock of each period
//   overrun_out       one-cycle pulse when an unconsumed pending sample is replaced
module pwm_dac_out
    import pwm_dac_pkg::*;
#(
    parameter int RES = 10,
    parameter int DW  = 16
) (
    input  logic          clk_in,
    input  logic          reset_n_in,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid_in,
    input  logic          enable_in,
    input  logic          mode_in,
    output logic          pwm_out,
    output logic          period_start_out,
    output logic          overrun_out
);

    logic [RES-1:0] cnt_r;
    logic [DW-1:0]  pending_r;
    logic           pending_full_r;
    logic [DW-1:0]  cur_r;
    mode_e          mode_q_r;
    logic           pwm_r;
    logic           period_start_r;
    logic           overrun_r;

    logic [DW-1:0]  offs_s;
    logic           load_s;
    logic           mode_change_s;
    logic           dsm_clear_s;
    logic           dsm_en_s;
    logic           dsm_carry_s;
    logic [RES-1:0] duty_s;
    logic           pwm_next_s;

    // Period control, capture conversion and next output bit selection.
    always_comb begin
        offs_s        = to_offset_binary(sample_in);
        load_s        = enable_in && (cnt_r == {RES{1'b1}});
        // The accumulator restarts from zero whenever the latched mode flips,
        // on the same edge that latches the new mode.
        mode_change_s = load_s && (mode_e'(mode_in) != mode_q_r);
        dsm_clear_s   = !enable_in || mode_change_s;
        dsm_en_s      = enable_in && (mode_q_r == MODE_DSM);
        duty_s        = cur_r[DW-1 -: RES];
        if (!enable_in) begin
            pwm_next_s = 1'b0;
        end else if (mode_q_r == MODE_DSM) begin
            pwm_next_s = dsm_carry_s;
        end else begin
            pwm_next_s = (cnt_r < duty_s);
        end
    end

    // Period counter: free-running while enabled, parked at zero otherwise.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            cnt_r <= {RES{1'b0}};
        end else if (!enable_in) begin
            cnt_r <= {RES{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(RES-1){1'b0}}, 1'b1};
        end
    end

    // Pending buffer: a strobe on the load cycle becomes the new pending
    // sample while the load itself consumes the old one.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            pending_r      <= {DW{1'b0}};
            pending_full_r <= 1'b0;
        end else begin
            if (sample_valid_in) begin
                pending_r <= offs_s;
            end else begin
                pending_r <= pending_r;
            end
            if (load_s) begin
                pending_full_r <= sample_valid_in;
            end else if (sample_valid_in) begin
                pending_full_r <= 1'b1;
            end else begin
                pending_full_r <= pending_full_r;
            end
        end
    end

    // Active sample and latched mode, updated only on the load cycle.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            cur_r    <= MIDSCALE;
            mode_q_r <= MODE_PWM;
        end else if (load_s) begin
            cur_r    <= pending_full_r ? pending_r : cur_r;
            mode_q_r <= mode_e'(mode_in);
        end else begin
            cur_r    <= cur_r;
            mode_q_r <= mode_q_r;
        end
    end

    // Registered pin, period marker and overrun flag.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            pwm_r          <= 1'b0;
            period_start_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            pwm_r          <= pwm_next_s;
            period_start_r <= load_s;
            overrun_r      <= sample_valid_in && pending_full_r && !load_s;
        end
    end

    dsm_modulator #(
        .DW (DW)
    ) u_dsm (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .clear_in   (dsm_clear_s),
        .enable_in  (dsm_en_s),
        .level_in   (cur_r),
        .carry_out  (dsm_carry_s)
    );

    assign pwm_out          = pwm_r;
    assign period_start_out = period_start_r;
    assign overrun_out      = overrun_r;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Self-checking bench for pwm_dac_out. The reference model works per period:
// a PWM bit is (position < level/64); a DSM bit is the increment of
// floor(running_sum / 65536) where running_sum adds the level every clock
// since the last restart.
module tb_pwm_dac_out;

    localparam int PER = 1024;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic        enable_in;
    logic        mode_in;
    logic        pwm_out;
    logic        period_start_out;
    logic        overrun_out;

    int     checks = 0;
    int     errors = 0;
    longint dsm_sum = 0;
    bit     model_mode = 1'b0;

    always #5 clk_in = ~clk_in;

    pwm_dac_out dut (
        .clk_in           (clk_in),
        .reset_n_in       (reset_n_in),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .enable_in        (enable_in),
        .mode_in          (mode_in),
        .pwm_out          (pwm_out),
        .period_start_out (period_start_out),
        .overrun_out      (overrun_out)
    );

    // Offset-binary level the DAC should hold for a signed sample.
    function automatic logic [15:0] level_of(input logic [15:0] s);
        int v;
        v = $signed(s) + 32768;
        return v[15:0];
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One full period starting at a period boundary: optional samples at steps
    // t1/t2, optional mode_in change at t_mode. Checks every output bit, the
    // period_start pulse at exactly step PER, and the overrun pulse count.
    task automatic run_period(input logic [15:0] exp_cur, input bit exp_dsm,
                              input int t1, input logic [15:0] s1,
                              input int t2, input logic [15:0] s2,
                              input int t_mode, input bit new_mode,
                              input int exp_ovr, input string name,
                              output int highs);
        int bad = 0;
        int first_bad = -1;
        int ovr = 0;
        int ps_early = 0;
        bit ps_last = 1'b0;
        bit exp_bit;
        if (exp_dsm != model_mode) dsm_sum = 0;
        model_mode = exp_dsm;
        highs = 0;
        for (int i = 1; i <= PER; i++) begin
            sample_valid_in = (i == t1) || (i == t2);
            sample_in       = (i == t2) ? s2 : ((i == t1) ? s1 : 16'($urandom));
            if (i == t_mode) mode_in = new_mode;
            step();
            sample_valid_in = 1'b0;
            if (exp_dsm) begin
                exp_bit = ((dsm_sum + longint'(exp_cur)) / 65536) != (dsm_sum / 65536);
                dsm_sum = dsm_sum + longint'(exp_cur);
            end else begin
                exp_bit = (i - 1) < int'(exp_cur[15:6]);
            end
            if (pwm_out !== exp_bit) begin
                bad++;
                if (first_bad < 0) first_bad = i - 1;
            end
            if (pwm_out === 1'b1) highs++;
            if (overrun_out === 1'b1) ovr++;
            if (period_start_out === 1'b1) begin
                if (i == PER) ps_last = 1'b1;
                else ps_early++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s bits: %0d wrong (first at %0d), required 0", name, bad, first_bad);
        end
        checks++;
        if (ps_last !== 1'b1 || ps_early !== 0) begin
            errors++;
            $display("FAIL %s period_start: at_end=%0d early=%0d, required 1/0", name, ps_last, ps_early);
        end
        checks++;
        if (ovr !== exp_ovr) begin
            errors++;
            $display("FAIL %s overrun: got %0d pulses, required %0d", name, ovr, exp_ovr);
        end
    endtask

    task automatic test_reset();
        int h;
        int bad = 0;
        reset_n_in = 1'b0; enable_in = 1'b1; mode_in = 1'b0;
        sample_valid_in = 1'b0; sample_in = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step();
            if (pwm_out !== 1'b0 || period_start_out !== 1'b0 || overrun_out !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_outputs: %0d nonzero samples, required 0", bad);
        end
        reset_n_in = 1'b1;
        dsm_sum = 0; model_mode = 1'b0;
        run_period(16'h8000, 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "reset_mid", h);
        checks++;
        if (h !== 512) begin
            errors++;
            $display("FAIL reset_duty: high %0d, required 512", h);
        end
    endtask

    task automatic test_pwm_extremes();
        int h;
        run_period(16'h8000, 1'b0, 500, 16'h7FFF, -1, 16'h0, -1, 1'b0, 0, "ext_load", h);
        run_period(16'hFFFF, 1'b0, 300, 16'h8000, -1, 16'h0, -1, 1'b0, 0, "ext_max", h);
        checks++;
        if (h !== 1023) begin
            errors++;
            $display("FAIL ext_max_duty: high %0d, required 1023", h);
        end
        run_period(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "ext_zero", h);
        checks++;
        if (h !== 0) begin
            errors++;
            $display("FAIL ext_zero_duty: high %0d, required 0", h);
        end
    endtask

    task automatic test_random_pwm(inout logic [15:0] cur);
        int h;
        logic [15:0] s;
        for (int k = 0; k < 4; k++) begin
            s = 16'($urandom);
            run_period(cur, 1'b0, $urandom_range(1, PER - 1), s, -1, 16'h0, -1, 1'b0, 0, "rand_pwm", h);
            cur = level_of(s);
        end
        run_period(cur, 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "rand_pwm_last", h);
    endtask

    task automatic test_overrun(inout logic [15:0] cur);
        int h;
        logic [15:0] x, y, a, b;
        x = 16'($urandom); y = 16'($urandom); a = 16'($urandom); b = 16'($urandom);
        run_period(cur, 1'b0, 100, x, 400, y, -1, 1'b0, 1, "ovr_two", h);
        run_period(level_of(y), 1'b0, 200, a, PER, b, -1, 1'b0, 0, "ovr_on_load", h);
        run_period(level_of(a), 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "ovr_old_pending", h);
        run_period(level_of(b), 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "ovr_new_pending", h);
        cur = level_of(b);
    endtask

    task automatic test_dsm(inout logic [15:0] cur);
        int h;
        int total = 0;
        logic [15:0] r;
        // mode_in flips mid-period; this period must stay PWM.
        run_period(cur, 1'b0, 300, 16'h4000, -1, 16'h0, 500, 1'b1, 0, "dsm_deferred", h);
        for (int k = 0; k < 4; k++) begin
            run_period(16'hC000, 1'b1, (k == 3) ? 600 : -1, 16'h0000, -1, 16'h0, -1, 1'b1, 0, "dsm_c000", h);
            total += h;
        end
        checks++;
        if (total !== 3072) begin
            errors++;
            $display("FAIL dsm_density: high %0d of 4096, required 3072", total);
        end
        r = 16'($urandom);
        run_period(16'h8000, 1'b1, 700, r, -1, 16'h0, -1, 1'b1, 0, "dsm_alternate", h);
        checks++;
        if (h !== 512) begin
            errors++;
            $display("FAIL dsm_half: high %0d, required 512", h);
        end
        run_period(level_of(r), 1'b1, -1, 16'h0, -1, 16'h0, 800, 1'b0, 0, "dsm_random", h);
        run_period(level_of(r), 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "dsm_back_pwm", h);
        cur = level_of(r);
    endtask

    task automatic test_enable(inout logic [15:0] cur);
        int h;
        int highs = 0;
        int ps = 0;
        int ovr = 0;
        logic [15:0] s1, s2;
        s1 = 16'($urandom); s2 = 16'($urandom);
        for (int i = 0; i < 300; i++) step();
        enable_in = 1'b0;
        for (int i = 1; i <= 3000; i++) begin
            sample_valid_in = (i == 1000) || (i == 2000);
            sample_in = (i == 2000) ? s2 : s1;
            step();
            sample_valid_in = 1'b0;
            if (pwm_out !== 1'b0) highs++;
            if (period_start_out !== 1'b0) ps++;
            if (overrun_out === 1'b1) ovr++;
        end
        checks++;
        if (highs !== 0 || ps !== 0) begin
            errors++;
            $display("FAIL disabled_quiet: pwm high %0d period_start %0d, required 0/0", highs, ps);
        end
        checks++;
        if (ovr !== 1) begin
            errors++;
            $display("FAIL disabled_overrun: got %0d pulses, required 1", ovr);
        end
        enable_in = 1'b1;
        dsm_sum = 0;
        run_period(cur, 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "enable_first", h);
        run_period(level_of(s2), 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "enable_loaded", h);
        cur = level_of(s2);
    endtask

    task automatic test_reset_mid();
        int h;
        int bad = 0;
        for (int i = 1; i <= 400; i++) begin
            sample_valid_in = (i == 100);
            sample_in = 16'h7FFF;
            step();
            sample_valid_in = 1'b0;
        end
        reset_n_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (pwm_out !== 1'b0 || period_start_out !== 1'b0 || overrun_out !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_mid_outputs: %0d nonzero samples, required 0", bad);
        end
        reset_n_in = 1'b1;
        dsm_sum = 0; model_mode = 1'b0;
        run_period(16'h8000, 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "reset_mid_first", h);
        checks++;
        if (h !== 512) begin
            errors++;
            $display("FAIL reset_mid_duty: high %0d, required 512", h);
        end
        run_period(16'h8000, 1'b0, -1, 16'h0, -1, 16'h0, -1, 1'b0, 0, "reset_mid_no_pending", h);
    endtask

    initial begin
        logic [15:0] cur;
        test_reset();
        test_pwm_extremes();
        cur = 16'h0000;
        test_random_pwm(cur);
        test_overrun(cur);
        test_dsm(cur);
        test_enable(cur);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_dac_out.md
Name: pwm_dac_out

Overview:
- Audio output stage directly downstream of the tone-generator mixer.
- Accepts the signed 16-bit mixed sample and its one-cycle valid pulse, which arrive once per 1024-clock frame.
- Double-buffers the sample and drives a single-bit output pin, selectable between plain PWM and first-order delta-sigma (DSM).
- Sits between the mixer and the chip output pad; an external RC filter recovers audio.

Parameters:
RES, 10, PWM resolution in bits; PWM period is 2^RES clocks (default matches the 1024-clock frame).
DW, 16, sample width in bits; fixed at 16 for this design.

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  synchronous reset, active-low
sample_in  input  16  signed two's-complement mixed sample
sample_valid_in  input  1  one-cycle strobe; sample_in is valid this cycle
enable_in  input  1  1 = modulator running; 0 = output parked low
mode_in  input  1  0 = PWM, 1 = DSM; sampled at period start
pwm_out  output  1  registered 1-bit DAC output
period_start_out  output  1  one-cycle pulse when a new period begins
overrun_out  output  1  one-cycle pulse when an unconsumed pending sample is overwritten

Behaviour:
- Clocking and reset
  - One clock domain (clk_in). Reset is synchronous and active-low on reset_n_in.
  - Reset values: pwm_out=0, period_start_out=0, overrun_out=0, pending_full=0, cnt=0, acc=0, mode_q=0.
  - Reset value of cur (active sample, offset binary) is 0x8000, i.e. midscale, to avoid a turn-on pop.
  - Reset mid-period abandons the period; no output glitch beyond forcing pwm_out low.
- Format conversion
  - offs = sample_in XOR 0x8000 (signed to offset binary). No other arithmetic on capture.
- Pending buffer
  - On sample_valid_in: pending <= offs, pending_full <= 1.
  - overrun_out pulses the next cycle when sample_valid_in=1, pending_full=1, and that cycle is not a load cycle. The new sample still overwrites the pending one.
- Period counter
  - cnt is RES bits, increments every clock while enable_in=1, and wraps 2^RES-1 -> 0.
  - Load cycle = the cycle where cnt==2^RES-1 and enable_in=1. On a load cycle:
    - if pending_full, then cur <= pending and pending_full <= 0; otherwise cur holds (repeat the last sample);
    - mode_q <= mode_in.
  - Valid on a load cycle: the load uses the old pending value, the incoming sample becomes the new pending value (pending_full=1), and overrun_out does not pulse.
  - period_start_out = registered (load cycle), so it is high on the cycle cnt==0.
- PWM mode (mode_q=0)
  - duty = cur[15:16-RES].
  - pwm_out <= (cnt < duty), registered, one cycle latency.
  - duty=0: output constantly 0. duty=2^RES-1: output high 2^RES-1 of 2^RES clocks.
- DSM mode (mode_q=1)
  - Per clock: {carry, acc} <= acc + cur (17-bit sum, 16-bit acc); pwm_out <= carry.
  - Output mean equals cur/65536.
  - acc is cleared on every mode_q change.
- enable_in=0
  - cnt and acc are held at 0 and pwm_out <= 0; no load cycles occur and period_start_out stays 0.
  - Pending capture and overrun detection continue.
  - After enable_in rises, the first load occurs 2^RES clocks later. Until then cur is unchanged and the output uses it.

Decomposition:
- Package pwm_dac_pkg holds: MODE_PWM=1'b0, MODE_DSM=1'b1, MIDSCALE=16'h8000, SIGN_FLIP=16'h8000.
- One sub-module: dsm_modulator (accumulator plus carry output, with clear and enable inputs).
- Counter, buffer and PWM comparator stay in the top module.

Test Plan:
- Reset, enable=1, no samples -> cur=0x8000, PWM duty 512: pwm_out high exactly 512 of every 1024 clocks; period_start_out every 1024 clocks.
- sample 0x7FFF valid mid-period, PWM -> next period duty 1023 (one low clock per period); sample 0x8000 -> pwm_out stuck 0.
- Two valids without an intervening load -> one overrun_out pulse, and the second sample is the one loaded. Valid exactly on the load cycle -> no overrun, and the loaded value is the previous pending sample.
- DSM mode with sample 0x4000 (cur 0xC000) -> pwm_out high 49152 of 65536 clocks. cur 0x8000 -> strict alternating 1/0 after settling.
- mode_in toggled mid-period -> change takes effect only at the next period_start_out, and acc starts from 0.
- enable_in low for 3000 clocks, then high; reset_n_in pulsed mid-period -> pwm_out 0 while disabled or in reset, first period_start_out 1024 clocks after enable/reset release, cur back at 0x8000 after reset.
